tlc_phase_sched: RTL and testbench

TLC_PHASE_SCHED -- requirements
Module: tlc_phase_sched

---
 rtl/tlc_phase_sched_if.sv | 29 ++
 rtl/tlc_phase_sched.sv | 141 ++++++++++++++
 tb/tb_tlc_phase_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/tlc_phase_sched_if.sv
// Bus between the traffic-light phase scheduler, its request sources and the shared down-counting timer.
// The slave modport is the scheduler; the master modport is the environment driving requests and the timer.
interface tlc_phase_sched_if #(
  parameter int N = 4
);
  logic         clk_en;
  logic         car_ns;
  logic         car_ew;
  logic         ped;
  logic         emerg_ns;
  logic         emerg_ew;
  logic [N-1:0] timer_out;
  logic         timer_en;
  logic         timer_load;
  logic [N-1:0] timer_init;
  logic [1:0]   grant;
  logic         yellow;
  logic [2:0]   pending;

  modport master (
    output clk_en, car_ns, car_ew, ped, emerg_ns, emerg_ew, timer_out,
    input  timer_en, timer_load, timer_init, grant, yellow, pending
  );

  modport slave (
    input  clk_en, car_ns, car_ew, ped, emerg_ns, emerg_ew, timer_out,
    output timer_en, timer_load, timer_init, grant, yellow, pending
  );
endinterface

// File: rtl/tlc_phase_sched.sv
// Traffic-light phase scheduler: latches service requests, sequences green/yellow/all-red/walk
// phases on clock-divider ticks using an external shared timer, with emergency preemption.
module tlc_phase_sched #(
  parameter int N        = 4,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 5,
  parameter int PED_T    = 15,
  parameter int ALLRED_T = 1
) (
  input  logic             clk,
  input  logic             rst,
  tlc_phase_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALLRED, S_GRN_NS, S_YEL_NS, S_GRN_EW, S_YEL_EW, S_WALK
  } state_t;

  typedef enum logic [1:0] {
    L_NS  = 2'd1,
    L_EW  = 2'd2,
    L_PED = 2'd3
  } served_t;

  localparam logic [N-1:0] GREEN_V  = N'(GREEN_T);
  localparam logic [N-1:0] YELLOW_V = N'(YELLOW_T);
  localparam logic [N-1:0] PED_V    = N'(PED_T);
  localparam logic [N-1:0] ALLRED_V = N'(ALLRED_T);

  state_t     state_q, state_d;
  state_t     arb_state;
  served_t    last_q, last_d;
  logic       fresh_q, fresh_d;
  logic [2:0] pending_q, pending_d;
  logic       expiry;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      last_q    <= L_PED;
      fresh_q   <= 1'b0;
      pending_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      fresh_q   <= fresh_d;
      pending_q <= pending_d;
    end
  end

  assign expiry = bus.clk_en && !fresh_q && (bus.timer_out == '0);

  // Round-robin over latched requests, starting with the service after last_q.
  always_comb begin
    arb_state = S_IDLE;
    if (bus.emerg_ns) begin
      arb_state = S_GRN_NS;
    end else if (bus.emerg_ew) begin
      arb_state = S_GRN_EW;
    end else begin
      unique case (last_q)
        L_NS: begin
          if      (pending_q[1]) arb_state = S_GRN_EW;
          else if (pending_q[2]) arb_state = S_WALK;
          else if (pending_q[0]) arb_state = S_GRN_NS;
        end
        L_EW: begin
          if      (pending_q[2]) arb_state = S_WALK;
          else if (pending_q[0]) arb_state = S_GRN_NS;
          else if (pending_q[1]) arb_state = S_GRN_EW;
        end
        default: begin
          if      (pending_q[0]) arb_state = S_GRN_NS;
          else if (pending_q[1]) arb_state = S_GRN_EW;
          else if (pending_q[2]) arb_state = S_WALK;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clk_en) begin
      unique case (state_q)
        S_IDLE:   if (|pending_q || bus.emerg_ns || bus.emerg_ew) state_d = S_ALLRED;
        S_ALLRED: if (expiry) state_d = arb_state;
        // An emergency for the green direction holds it, and NS wins when both are raised.
        S_GRN_NS: if (!bus.emerg_ns && (bus.emerg_ew || expiry)) state_d = S_YEL_NS;
        S_GRN_EW: if (bus.emerg_ns || (!bus.emerg_ew && expiry)) state_d = S_YEL_EW;
        S_YEL_NS: if (expiry) state_d = S_ALLRED;
        S_YEL_EW: if (expiry) state_d = S_ALLRED;
        S_WALK:   if (bus.emerg_ns || bus.emerg_ew || expiry) state_d = S_ALLRED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fresh_d   = fresh_q;
    last_d    = last_q;
    pending_d = pending_q | {bus.ped, bus.car_ew, bus.car_ns};
    if (state_d != state_q) begin
      fresh_d = (state_d != S_IDLE);
      unique case (state_d)
        S_GRN_NS: begin pending_d[0] = 1'b0; last_d = L_NS;  end
        S_GRN_EW: begin pending_d[1] = 1'b0; last_d = L_EW;  end
        S_WALK:   begin pending_d[2] = 1'b0; last_d = L_PED; end
        default: ;
      endcase
    end else if (bus.clk_en) begin
      fresh_d = 1'b0;
    end
  end

  always_comb begin
    bus.grant      = 2'd0;
    bus.yellow     = 1'b0;
    bus.timer_en   = (state_q != S_IDLE);
    bus.timer_load = fresh_q;
    bus.timer_init = '0;
    bus.pending    = pending_q;
    unique case (state_q)
      S_GRN_NS: bus.grant = 2'd1;
      S_YEL_NS: begin bus.grant = 2'd1; bus.yellow = 1'b1; end
      S_GRN_EW: bus.grant = 2'd2;
      S_YEL_EW: begin bus.grant = 2'd2; bus.yellow = 1'b1; end
      S_WALK:   bus.grant = 2'd3;
      default: ;
    endcase
    if (fresh_q) begin
      unique case (state_q)
        S_ALLRED:           bus.timer_init = ALLRED_V;
        S_GRN_NS, S_GRN_EW: bus.timer_init = GREEN_V;
        S_YEL_NS, S_YEL_EW: bus.timer_init = YELLOW_V;
        S_WALK:             bus.timer_init = PED_V;
        default:            bus.timer_init = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Directed bench for tlc_phase_sched with a behavioural model of the shared down-counting timer.
module tb_tlc_phase_sched;
  localparam int N        = 4;
  localparam int GREEN_T  = 10;
  localparam int YELLOW_T = 5;
  localparam int PED_T    = 15;
  localparam int ALLRED_T = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [N-1:0] tcnt_q;

  tlc_phase_sched_if #(.N(N)) bus ();

  tlc_phase_sched #(
    .N(N), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .PED_T(PED_T), .ALLRED_T(ALLRED_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Shared timer: load wins; otherwise counts down on enabled ticks, sticking at zero.
  // A phase therefore spans duration+2 ticks from entry to the tick that leaves it.
  always @(posedge clk) begin
    if (!rst)                                           tcnt_q <= '0;
    else if (bus.timer_load)                            tcnt_q <= bus.timer_init;
    else if (bus.timer_en && bus.clk_en && tcnt_q != 0) tcnt_q <= tcnt_q - 1'b1;
  end
  assign bus.timer_out = tcnt_q;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.clk_en = 1'b1;
    cycle();
    bus.clk_en = 1'b0;
    cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    bus.clk_en = 1'b0; bus.car_ns = 1'b0; bus.car_ew = 1'b0; bus.ped = 1'b0;
    bus.emerg_ns = 1'b0; bus.emerg_ew = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
  endtask

  task automatic wait_state(input logic [1:0] g, input logic y, input int max_ticks,
                            output int ticks, output bit found);
    ticks = 0;
    found = 1'b0;
    while (!found && ticks < max_ticks) begin
      do_tick();
      ticks++;
      if (bus.grant == g && bus.yellow == y) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.car_ns = 1'b1; bus.car_ew = 1'b1; bus.ped = 1'b1; bus.clk_en = 1'b1;
    bus.emerg_ns = 1'b0; bus.emerg_ew = 1'b0;
    repeat (3) cycle();
    bus.car_ns = 1'b0; bus.car_ew = 1'b0; bus.ped = 1'b0; bus.clk_en = 1'b0;
    rst = 1'b1;
    cycle();
    checks++; if (bus.grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", bus.grant); end
    checks++; if (bus.yellow !== 1'b0) begin errors++; $display("FAIL reset_yellow: got %0b expected 0", bus.yellow); end
    checks++; if (bus.timer_en !== 1'b0) begin errors++; $display("FAIL reset_timer_en: got %0b expected 0", bus.timer_en); end
    checks++; if (bus.timer_load !== 1'b0) begin errors++; $display("FAIL reset_timer_load: got %0b expected 0", bus.timer_load); end
    checks++; if (bus.timer_init !== 4'd0) begin errors++; $display("FAIL reset_timer_init: got %0d expected 0", bus.timer_init); end
    checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b expected 000", bus.pending); end
    $display("test_reset: grant=%0d pending=%b", bus.grant, bus.pending);
  endtask

  task automatic test_single_ns();
    int t; bit f;
    apply_reset();
    bus.car_ns = 1'b1; cycle(); bus.car_ns = 1'b0;
    cycle();
    checks++; if (bus.pending !== 3'b001) begin errors++; $display("FAIL single_pending: got %b expected 001", bus.pending); end
    checks++; if (bus.timer_en !== 1'b0) begin errors++; $display("FAIL single_idle_no_tick: timer_en got %0b expected 0", bus.timer_en); end
    do_tick();
    checks++; if (bus.timer_en !== 1'b1 || bus.grant !== 2'd0 || bus.timer_init !== 4'd1)
      begin errors++; $display("FAIL single_allred: en=%0b grant=%0d init=%0d expected 1 0 1", bus.timer_en, bus.grant, bus.timer_init); end
    wait_state(2'd1, 1'b0, 10, t, f);
    checks++; if (!f || t != ALLRED_T + 2) begin errors++; $display("FAIL single_allred_len: got %0d ticks expected %0d", t, ALLRED_T + 2); end
    checks++; if (bus.timer_load !== 1'b1 || bus.timer_init !== 4'd10)
      begin errors++; $display("FAIL single_green_load: load=%0b init=%0d expected 1 10", bus.timer_load, bus.timer_init); end
    checks++; if (bus.pending !== 3'b000) begin errors++; $display("FAIL single_pending_clear: got %b expected 000", bus.pending); end
    wait_state(2'd1, 1'b1, 30, t, f);
    checks++; if (!f || t != GREEN_T + 2) begin errors++; $display("FAIL single_green_len: got %0d ticks expected %0d", t, GREEN_T + 2); end
    checks++; if (bus.timer_init !== 4'd5) begin errors++; $display("FAIL single_yellow_init: got %0d expected 5", bus.timer_init); end
    wait_state(2'd0, 1'b0, 30, t, f);
    checks++; if (!f || t != YELLOW_T + 2) begin errors++; $display("FAIL single_yellow_len: got %0d ticks expected %0d", t, YELLOW_T + 2); end
    repeat (ALLRED_T + 2) do_tick();
    checks++; if (bus.timer_en !== 1'b0 || bus.grant !== 2'd0)
      begin errors++; $display("FAIL single_back_idle: en=%0b grant=%0d expected 0 0", bus.timer_en, bus.grant); end
    $display("test_single_ns: green ticks checked, back in idle");
  endtask

  task automatic test_alternate();
    logic [1:0] greens [4];
    logic [1:0] exp_g  [4];
    int n = 0;
    exp_g[0] = 2'd1; exp_g[1] = 2'd2; exp_g[2] = 2'd1; exp_g[3] = 2'd2;
    apply_reset();
    bus.car_ns = 1'b1; bus.car_ew = 1'b1;
    for (int k = 0; k < 150 && n < 4; k++) begin
      do_tick();
      if (bus.timer_load && !bus.yellow && bus.grant != 2'd0) begin
        greens[n] = bus.grant;
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL alt_count: got %0d greens expected 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (greens[i] !== exp_g[i]) begin errors++; $display("FAIL alt_green%0d: got %0d expected %0d", i, greens[i], exp_g[i]); end
    end
    bus.car_ns = 1'b0; bus.car_ew = 1'b0;
    $display("test_alternate: %0d greens observed", n);
  endtask

  task automatic test_ped();
    int t; bit f;
    apply_reset();
    bus.ped = 1'b1; bus.car_ns = 1'b1; cycle(); bus.ped = 1'b0; bus.car_ns = 1'b0;
    checks++; if (bus.pending !== 3'b101) begin errors++; $display("FAIL ped_pending: got %b expected 101", bus.pending); end
    wait_state(2'd1, 1'b0, 10, t, f);
    checks++; if (!f) begin errors++; $display("FAIL ped_ns_first: grant got %0d expected 1", bus.grant); end
    wait_state(2'd3, 1'b0, 60, t, f);
    checks++; if (!f || bus.timer_init !== 4'd15)
      begin errors++; $display("FAIL ped_walk_entry: grant=%0d init=%0d expected 3 15", bus.grant, bus.timer_init); end
    checks++; if (bus.pending[2] !== 1'b0) begin errors++; $display("FAIL ped_clear: got %0b expected 0", bus.pending[2]); end
    wait_state(2'd0, 1'b0, 40, t, f);
    checks++; if (!f || t != PED_T + 2) begin errors++; $display("FAIL ped_walk_len: got %0d ticks expected %0d", t, PED_T + 2); end
    $display("test_ped: walk served after NS");
  endtask

  task automatic test_preempt();
    int t; bit f;
    apply_reset();
    bus.car_ns = 1'b1; cycle(); bus.car_ns = 1'b0;
    wait_state(2'd1, 1'b0, 10, t, f);
    repeat (2) do_tick();
    bus.emerg_ew = 1'b1;
    do_tick();
    checks++; if (bus.grant !== 2'd1 || bus.yellow !== 1'b1)
      begin errors++; $display("FAIL preempt_yellow: grant=%0d yellow=%0b expected 1 1", bus.grant, bus.yellow); end
    wait_state(2'd2, 1'b0, 30, t, f);
    checks++; if (!f) begin errors++; $display("FAIL preempt_ew_green: grant got %0d expected 2", bus.grant); end
    repeat (20) do_tick();
    checks++; if (bus.grant !== 2'd2 || bus.yellow !== 1'b0)
      begin errors++; $display("FAIL preempt_hold: grant=%0d yellow=%0b expected 2 0", bus.grant, bus.yellow); end
    bus.emerg_ew = 1'b0;
    do_tick();
    checks++; if (bus.grant !== 2'd2 || bus.yellow !== 1'b1)
      begin errors++; $display("FAIL preempt_release: grant=%0d yellow=%0b expected 2 1", bus.grant, bus.yellow); end
    $display("test_preempt: EW held then released");
  endtask

  task automatic test_both_emerg();
    int t; bit f;
    apply_reset();
    bus.emerg_ns = 1'b1; bus.emerg_ew = 1'b1;
    do_tick();
    checks++; if (bus.timer_en !== 1'b1 || bus.grant !== 2'd0)
      begin errors++; $display("FAIL both_allred: en=%0b grant=%0d expected 1 0", bus.timer_en, bus.grant); end
    wait_state(2'd1, 1'b0, 10, t, f);
    checks++; if (!f) begin errors++; $display("FAIL both_ns_wins: grant got %0d expected 1", bus.grant); end
    repeat (15) do_tick();
    checks++; if (bus.grant !== 2'd1 || bus.yellow !== 1'b0)
      begin errors++; $display("FAIL both_hold: grant=%0d yellow=%0b expected 1 0", bus.grant, bus.yellow); end
    bus.emerg_ns = 1'b0; bus.emerg_ew = 1'b0;
    $display("test_both_emerg: NS granted and held");
  endtask

  task automatic test_reset_mid();
    int t; bit f;
    apply_reset();
    bus.car_ew = 1'b1; cycle(); bus.car_ew = 1'b0;
    wait_state(2'd2, 1'b1, 40, t, f);
    checks++; if (!f) begin errors++; $display("FAIL mid_reach_yel_ew: grant=%0d yellow=%0b expected 2 1", bus.grant, bus.yellow); end
    bus.car_ns = 1'b1; cycle(); bus.car_ns = 1'b0;
    checks++; if (bus.pending !== 3'b001) begin errors++; $display("FAIL mid_pending_set: got %b expected 001", bus.pending); end
    rst = 1'b0;
    cycle();
    checks++; if (bus.grant !== 2'd0 || bus.yellow !== 1'b0 || bus.timer_en !== 1'b0 || bus.pending !== 3'b000)
      begin errors++; $display("FAIL mid_reset: grant=%0d yellow=%0b en=%0b pending=%b expected 0 0 0 000",
                               bus.grant, bus.yellow, bus.timer_en, bus.pending); end
    rst = 1'b1;
    cycle();
    $display("test_reset_mid: aborted during YEL_EW");
  endtask

  initial begin
    bus.clk_en = 1'b0; bus.car_ns = 1'b0; bus.car_ew = 1'b0; bus.ped = 1'b0;
    bus.emerg_ns = 1'b0; bus.emerg_ew = 1'b0;
    test_reset();
    test_single_ns();
    test_alternate();
    test_ped();
    test_preempt();
    test_both_emerg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
